// File: rtl/fdiv_arbiter_pkg.sv
// Shared flag indices and requester/tag types for the two-port FP divider arbiter.
package fdiv_arbiter_pkg;

  localparam int FLAG_W = 3;
  localparam int OVF    = 2;
  localparam int UNF    = 1;
  localparam int EXC    = 0;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

endpackage

// File: rtl/fdiv_rsp_fifo.sv
// First-word fall-through response FIFO; a pop and a write on a full FIFO both succeed.
module fdiv_rsp_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wrEn_i,
  input  logic [W-1:0] wrData_i,
  input  logic         popReady_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPop, doWrite;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rdPtr_q];
  assign doPop   = popReady_i && valid_o;
  assign doWrite = wrEn_i && ((count_q != CW'(DEPTH)) || doPop);

  always_comb begin
    wrPtr_d = doWrite ? bump(wrPtr_q) : wrPtr_q;
    rdPtr_d = doPop ? bump(rdPtr_q) : rdPtr_q;
    count_d = count_q;
    if (doWrite && !doPop) begin
      count_d = count_q + CW'(1);
    end else if (doPop && !doWrite) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is cleared too so the response outputs read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) begin
        mem_q[wrPtr_q] <= wrData_i;
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fdiv_arbiter.sv
// Round-robin, credit-based arbiter sharing one pipelined FP divider between two requesters.
module fdiv_arbiter
  import fdiv_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LAT       = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [XLEN-1:0]   rsp0_result,
  output logic [FLAG_W-1:0] rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [XLEN-1:0]   rsp1_result,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic              div_valid,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  input  logic [XLEN-1:0]   div_result,
  input  logic [FLAG_W-1:0] div_flags
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int RW = XLEN + FLAG_W;

  logic [CW-1:0]   credit0_q, credit0_d, credit1_q, credit1_d;
  req_id_e         prioPtr_q, prioPtr_d;
  logic            elig0, elig1, grant0, grant1, grantAny;
  logic            pop0, pop1, wr0, wr1;
  logic            divValid_q;
  logic [XLEN-1:0] divA_q, divB_q;
  tag_t            tag_q [LAT];
  logic [RW-1:0]   divWord, rspWord0, rspWord1;

  function automatic logic [CW-1:0] nextCredit(input logic [CW-1:0] c, input logic inc,
                                               input logic dec);
    if (inc && !dec) return c + CW'(1);
    if (dec && !inc) return c - CW'(1);
    return c;
  endfunction

  // Credits cover in-flight ops plus queued responses, so a landing result always has room.
  // Eligibility is gated by reset so no ready leaks out while reset is held.
  assign elig0 = reset && req0_valid && (credit0_q < CW'(RSP_DEPTH));
  assign elig1 = reset && req1_valid && (credit1_q < CW'(RSP_DEPTH));

  always_comb begin
    grant0 = elig0;
    grant1 = elig1;
    if (elig0 && elig1) begin
      grant0 = (prioPtr_q == REQ0);
      grant1 = (prioPtr_q == REQ1);
    end
  end

  assign grantAny   = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign pop0       = rsp0_valid && rsp0_ready;
  assign pop1       = rsp1_valid && rsp1_ready;
  assign prioPtr_d  = grantAny ? (grant0 ? REQ1 : REQ0) : prioPtr_q;
  assign credit0_d  = nextCredit(credit0_q, grant0, pop0);
  assign credit1_d  = nextCredit(credit1_q, grant1, pop1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit0_q  <= '0;
      credit1_q  <= '0;
      prioPtr_q  <= REQ0;
      divValid_q <= 1'b0;
      divA_q     <= '0;
      divB_q     <= '0;
    end else begin
      credit0_q  <= credit0_d;
      credit1_q  <= credit1_d;
      prioPtr_q  <= prioPtr_d;
      divValid_q <= grantAny;
      if (grantAny) begin
        divA_q <= grant0 ? req0_a : req1_a;
        divB_q <= grant0 ? req0_b : req1_b;
      end
    end
  end

  // The tag enters alongside the grant, so its last stage lines up with div_result
  // LAT cycles after the handshake cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '{valid: 1'b0, id: REQ0};
      end
    end else begin
      tag_q[0] <= '{valid: grantAny, id: (grant1 ? REQ1 : REQ0)};
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign div_valid = divValid_q;
  assign div_a     = divA_q;
  assign div_b     = divB_q;
  assign divWord   = {div_flags, div_result};
  assign wr0       = tag_q[LAT-1].valid && (tag_q[LAT-1].id == REQ0);
  assign wr1       = tag_q[LAT-1].valid && (tag_q[LAT-1].id == REQ1);

  fdiv_rsp_fifo #(.W(RW), .DEPTH(RSP_DEPTH)) u_rspFifo0 (
    .clk        (clk),
    .reset      (reset),
    .wrEn_i     (wr0),
    .wrData_i   (divWord),
    .popReady_i (rsp0_ready),
    .valid_o    (rsp0_valid),
    .data_o     (rspWord0)
  );

  fdiv_rsp_fifo #(.W(RW), .DEPTH(RSP_DEPTH)) u_rspFifo1 (
    .clk        (clk),
    .reset      (reset),
    .wrEn_i     (wr1),
    .wrData_i   (divWord),
    .popReady_i (rsp1_ready),
    .valid_o    (rsp1_valid),
    .data_o     (rspWord1)
  );

  assign rsp0_result = rspWord0[XLEN-1:0];
  assign rsp1_result = rspWord1[XLEN-1:0];
  assign rsp0_flags  = {rspWord0[XLEN+OVF], rspWord0[XLEN+UNF], rspWord0[XLEN+EXC]};
  assign rsp1_flags  = {rspWord1[XLEN+OVF], rspWord1[XLEN+UNF], rspWord1[XLEN+EXC]};

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Directed bench for fdiv_arbiter with a stand-in pipelined divider and per-requester scoreboards.
module tb_fdiv_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic        div_valid;
  logic [31:0] div_a, div_b, div_result;
  logic [2:0]  div_flags;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [34:0] q0 [$];
  logic [34:0] q1 [$];
  logic [63:0] divPipe [LAT-1];

  always #5 clk = ~clk;

  fdiv_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_flags(rsp1_flags),
    .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_flags(div_flags)
  );

  // Stand-in divider: returns {flags, quotient}; zero divisor raises the exception bit.
  function automatic logic [34:0] divModel(input logic [31:0] a, input logic [31:0] b);
    if (b[30:0] == 31'd0) return {3'b001, 32'h7F800000};
    if (a == 32'h40866666 && b == 32'h404CCCCC) return {3'b000, 32'h3FA80000};
    return {a[2:0], a ^ b};
  endfunction

  // Result appears LAT cycles after the grant cycle, i.e. LAT-1 after div_valid.
  always @(posedge clk) begin
    divPipe[0] <= {div_a, div_b};
    for (int i = 1; i < LAT - 1; i++) divPipe[i] <= divPipe[i-1];
  end
  assign {div_flags, div_result} = divModel(divPipe[LAT-2][63:32], divPipe[LAT-2][31:0]);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic r0, input logic r1);
    logic [34:0] expWord;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    if (rsp0_valid && rsp0_ready) begin
      expWord = (q0.size() != 0) ? q0.pop_front() : 'x;
      checkOutput("sb_rsp0", {rsp0_flags, rsp0_result}, expWord);
    end
    if (rsp1_valid && rsp1_ready) begin
      expWord = (q1.size() != 0) ? q1.pop_front() : 'x;
      checkOutput("sb_rsp1", {rsp1_flags, rsp1_result}, expWord);
    end
    if (req0_valid && req0_ready) q0.push_back(divModel(req0_a, req0_b));
    if (req1_valid && req1_ready) q1.push_back(divModel(req1_a, req1_b));
  endtask

  task automatic idle(input logic r0, input logic r1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, r0, r1);
  endtask

  // Directed sequence: reset, single op, contention, backpressure, credit edge, flags, reset mid-op.
  initial begin
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hDEADBEEF; req0_b = 32'h1;
    req1_valid = 1'b1; req1_a = 32'h0; req1_b = 32'h1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    checkOutput("rst_div_valid", div_valid, 0);
    checkOutput("rst_div_a", div_a, 0);
    checkOutput("rst_div_b", div_b, 0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", rsp1_valid, 0);
    checkOutput("rst_rsp0_result", rsp0_result, 0);
    checkOutput("rst_rsp0_flags", rsp0_flags, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

    $display("[TB] single op latency");
    applyStimulus(1'b1, 32'h40866666, 32'h404CCCCC, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("single_req0_ready", req0_ready, 1);
    checkOutput("single_req1_ready", req1_ready, 0);
    idle(1'b0, 1'b0);
    checkOutput("single_div_valid", div_valid, 1);
    checkOutput("single_div_a", div_a, 32'h40866666);
    checkOutput("single_div_b", div_b, 32'h404CCCCC);
    checkOutput("single_rsp_c1", rsp0_valid, 0);
    idle(1'b0, 1'b0);
    checkOutput("single_div_valid_drop", div_valid, 0);
    checkOutput("single_rsp_c2", rsp0_valid, 0);
    idle(1'b0, 1'b0);
    checkOutput("single_rsp_c3", rsp0_valid, 0);
    idle(1'b0, 1'b0);
    checkOutput("single_rsp_c4", rsp0_valid, 1);
    checkOutput("single_result", rsp0_result, 32'h3FA80000);
    checkOutput("single_flags", rsp0_flags, 3'b000);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    checkOutput("single_popped", rsp0_valid, 0);

    $display("[TB] contention after fresh reset");
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    q0.delete(); q1.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h10000000 + i, 32'h00010000, 1'b1, 32'h20000000 + i, 32'h00020000,
                    1'b1, 1'b1);
      checkOutput($sformatf("cont_ready0_%0d", i), req0_ready, (i % 2 == 0));
      checkOutput($sformatf("cont_ready1_%0d", i), req1_ready, (i % 2 == 1));
      if (i > 0) begin
        checkOutput($sformatf("cont_divv_%0d", i), div_valid, 1);
        checkOutput($sformatf("cont_diva_%0d", i), div_a,
                    ((i - 1) % 2 == 0) ? 32'h10000000 + i - 1 : 32'h20000000 + i - 1);
      end
    end
    idle(1'b1, 1'b1);
    checkOutput("cont_divv_last", div_valid, 1);
    repeat (8) idle(1'b1, 1'b1);
    checkOutput("cont_drain0", q0.size(), 0);
    checkOutput("cont_drain1", q1.size(), 0);

    $display("[TB] backpressure on requester 1");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'h30000000 + i, 32'h00000100, 1'b1, 32'h40000000 + i, 32'h00000200,
                    1'b1, 1'b0);
      checkOutput($sformatf("bp_ready0_%0d", i), req0_ready, (i >= 8) || (i % 2 == 0));
      checkOutput($sformatf("bp_ready1_%0d", i), req1_ready, (i < 8) && (i % 2 == 1));
    end
    checkOutput("bp_rsp1_held", rsp1_valid, 1);
    repeat (12) idle(1'b1, 1'b1);
    checkOutput("bp_drain0", q0.size(), 0);
    checkOutput("bp_drain1", q1.size(), 0);

    $display("[TB] pop and grant at credit RSP_DEPTH-1");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'h50000000 + i, 32'h00000400, 1'b0, 1'b0);
      checkOutput($sformatf("cr_fill_%0d", i), req1_ready, 1);
    end
    repeat (5) idle(1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'h50000003, 32'h00000400, 1'b0, 1'b1);
    checkOutput("cr_popgrant_ready", req1_ready, 1);
    checkOutput("cr_popgrant_valid", rsp1_valid, 1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'h50000004, 32'h00000400, 1'b0, 1'b0);
    checkOutput("cr_last_credit", req1_ready, 1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'h50000005, 32'h00000400, 1'b0, 1'b0);
    checkOutput("cr_exhausted", req1_ready, 0);
    repeat (10) idle(1'b1, 1'b1);
    checkOutput("cr_drain1", q1.size(), 0);

    $display("[TB] flag passthrough");
    applyStimulus(1'b1, 32'h3F800000, 32'h00000000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000006, 32'h3F800000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    checkOutput("exc_result", rsp0_result, 32'h7F800000);
    checkOutput("exc_flags", rsp0_flags, 3'b001);
    idle(1'b1, 1'b0);
    checkOutput("ovf_unf_result", rsp0_result, 32'h3F800006);
    checkOutput("ovf_unf_flags", rsp0_flags, 3'b110);
    repeat (3) idle(1'b1, 1'b1);

    $display("[TB] reset with ops in flight");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h60000000 + i, 32'h00000800, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    end
    repeat (2) idle(1'b0, 1'b0);
    checkOutput("mid_rsp_before", rsp0_valid, 1);
    reset = 1'b0; req0_valid = 1'b1;
    #1;
    checkOutput("mid_rsp_cleared", rsp0_valid, 0);
    checkOutput("mid_ready_blocked", req0_ready, 0);
    checkOutput("mid_result_zero", rsp0_result, 0);
    q0.delete(); q1.delete();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, 1'b1);
      checkOutput($sformatf("mid_stale0_%0d", i), rsp0_valid, 0);
      checkOutput($sformatf("mid_stale1_%0d", i), rsp1_valid, 0);
    end
    applyStimulus(1'b1, 32'h11110005, 32'h22220000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("post_ready", req0_ready, 1);
    repeat (3) begin
      idle(1'b0, 1'b0);
      checkOutput("post_wait", rsp0_valid, 0);
    end
    idle(1'b1, 1'b0);
    checkOutput("post_valid", rsp0_valid, 1);
    checkOutput("post_result", rsp0_result, 32'h33330005);
    checkOutput("post_flags", rsp0_flags, 3'b101);
    repeat (2) idle(1'b1, 1'b1);
    checkOutput("post_drain0", q0.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
